// File: rtl/conv_out_pkg.sv
// ----------------------------------------------------------------------------
// conv_out_pkg
//   Shared definitions for the convolution output path.
//   - DEF_INW / DEF_OUTW : default result and lane widths.
//   - sat_shift()        : optional ReLU, arithmetic right shift, then
//                          saturation to a signed outw-bit range.
//   Values are handled sign-extended to 32 bits so the helper serves any
//   input width up to 32 and any lane width below 32.
// ----------------------------------------------------------------------------
package conv_out_pkg;

   localparam int DEF_INW  = 24;
   localparam int DEF_OUTW = 8;

   function automatic logic signed [31:0] sat_shift(
      input logic signed [31:0] x,
      input int unsigned        shift,
      input logic               relu,
      input int unsigned        outw = DEF_OUTW
   );
      logic signed [31:0] v;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      v  = (relu && (x < 32'sd0)) ? 32'sd0 : x;
      v  = v >>> shift;
      hi = (32'sd1 <<< (outw - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/requant_lane.sv
// ----------------------------------------------------------------------------
// requant_lane
//   Combinational requantizer for one result.
//   Ports:
//     x     in  INW   signed input result
//     shift in  SHW   arithmetic right-shift amount
//     relu  in  1     clamp negative inputs to zero before shifting
//     y     out OUTW  saturated signed lane value
// ----------------------------------------------------------------------------
module requant_lane
   import conv_out_pkg::*;
#(
   parameter int INW  = DEF_INW,
   parameter int OUTW = DEF_OUTW,
   parameter int SHW  = $clog2(INW)
) (
   input  logic [INW-1:0]  x,
   input  logic [SHW-1:0]  shift,
   input  logic            relu,
   output logic [OUTW-1:0] y
);

   // Saturation guarantees the result fits in OUTW bits, so truncation is lossless.
   assign y = OUTW'(sat_shift(32'($signed(x)), 32'(shift), relu, OUTW));

endmodule

// File: rtl/out_requant_pack.sv
// ----------------------------------------------------------------------------
// out_requant_pack
//   Drains signed convolution results, requantizes each to OUTW bits and packs
//   PACK results per output word. The final word of every NUM_OUT-result frame
//   carries TLAST and a TKEEP covering only the lanes actually filled.
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     cfg_shift, cfg_relu         requant config, sampled at frame element 0
//     IN_AXIS_TDATA/TVALID/TREADY input result stream
//     OUT_AXIS_TDATA/TKEEP/TLAST/TVALID/TREADY  packed output stream
//                                 (lane 0 = earliest result, in the low bits)
// ----------------------------------------------------------------------------
module out_requant_pack
   import conv_out_pkg::*;
#(
   parameter int INW     = DEF_INW,
   parameter int OUTW    = DEF_OUTW,
   parameter int PACK    = 4,
   parameter int NUM_OUT = 36
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [$clog2(INW)-1:0] cfg_shift,
   input  logic                   cfg_relu,
   input  logic [INW-1:0]         IN_AXIS_TDATA,
   input  logic                   IN_AXIS_TVALID,
   output logic                   IN_AXIS_TREADY,
   output logic [PACK*OUTW-1:0]   OUT_AXIS_TDATA,
   output logic [PACK-1:0]        OUT_AXIS_TKEEP,
   output logic                   OUT_AXIS_TLAST,
   output logic                   OUT_AXIS_TVALID,
   input  logic                   OUT_AXIS_TREADY
);

   localparam int SHW        = $clog2(INW);
   localparam int LCW        = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int FCW        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int LAST_LANES = ((NUM_OUT - 1) % PACK) + 1;
   localparam logic [PACK-1:0] LAST_KEEP = PACK'((64'd1 << LAST_LANES) - 64'd1);

   logic [LCW-1:0]       lane_cnt_reg;
   logic [FCW-1:0]       frame_cnt_reg;
   logic [OUTW-1:0]      lanes_reg [PACK];
   logic [SHW-1:0]       shift_reg;
   logic                 relu_reg;
   logic [PACK*OUTW-1:0] out_data_reg;
   logic [PACK-1:0]      out_keep_reg;
   logic                 out_last_reg;
   logic                 out_valid_reg;

   logic                 in_ready;
   logic                 accept;
   logic                 frame_first;
   logic                 frame_last;
   logic                 word_done;
   logic [SHW-1:0]       eff_shift;
   logic                 eff_relu;
   logic [OUTW-1:0]      lane_val;
   logic [PACK*OUTW-1:0] word_next;

   // A single output register: room exists when it is empty or being drained.
   assign in_ready    = !reset && (!out_valid_reg || OUT_AXIS_TREADY);
   assign accept      = IN_AXIS_TVALID && in_ready;
   assign frame_first = (frame_cnt_reg == '0);
   assign frame_last  = (frame_cnt_reg == FCW'(NUM_OUT - 1));
   assign word_done   = accept && ((lane_cnt_reg == LCW'(PACK - 1)) || frame_last);

   // Element 0 of a frame uses the live config; later elements the latched copy.
   assign eff_shift = frame_first ? cfg_shift : shift_reg;
   assign eff_relu  = frame_first ? cfg_relu  : relu_reg;

   requant_lane #(
      .INW  (INW),
      .OUTW (OUTW),
      .SHW  (SHW)
   ) u_lane (
      .x     (IN_AXIS_TDATA),
      .shift (eff_shift),
      .relu  (eff_relu),
      .y     (lane_val)
   );

   // Assemble the word being completed: stored lanes below the current index,
   // the fresh result at it, zeros above (only reachable on a short last word).
   // Stale lane contents from a discarded partial word are masked the same way.
   generate
      for (genvar gi = 0; gi < PACK; gi++) begin : g_word
         assign word_next[gi*OUTW +: OUTW] =
            (LCW'(gi) == lane_cnt_reg) ? lane_val :
            (LCW'(gi) <  lane_cnt_reg) ? lanes_reg[gi] : '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (accept) begin
         lanes_reg[lane_cnt_reg] <= lane_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_cnt_reg  <= '0;
         frame_cnt_reg <= '0;
         shift_reg     <= '0;
         relu_reg      <= 1'b0;
         out_data_reg  <= '0;
         out_keep_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            lane_cnt_reg  <= word_done ? '0 : lane_cnt_reg + 1'b1;
            frame_cnt_reg <= frame_last ? '0 : frame_cnt_reg + 1'b1;
            if (frame_first) begin
               shift_reg <= cfg_shift;
               relu_reg  <= cfg_relu;
            end
         end
         // Loading wins over draining, so a same-cycle handshake keeps TVALID high.
         if (word_done) begin
            out_data_reg  <= word_next;
            out_keep_reg  <= frame_last ? LAST_KEEP : '1;
            out_last_reg  <= frame_last;
            out_valid_reg <= 1'b1;
         end else if (OUT_AXIS_TREADY) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign IN_AXIS_TREADY  = in_ready;
   assign OUT_AXIS_TDATA  = out_data_reg;
   assign OUT_AXIS_TKEEP  = out_keep_reg;
   assign OUT_AXIS_TLAST  = out_last_reg;
   assign OUT_AXIS_TVALID = out_valid_reg;

endmodule

// File: tb/tb_out_requant_pack.sv
// ----------------------------------------------------------------------------
// tb_out_requant_pack
//   Bench for out_requant_pack with NUM_OUT=6, PACK=4. Expected words come
//   from an arithmetic model of requantization and frame packing.
// ----------------------------------------------------------------------------
module tb_out_requant_pack;

   localparam int INW     = 24;
   localparam int OUTW    = 8;
   localparam int PACK    = 4;
   localparam int NUM_OUT = 6;

   logic                 clk;
   logic                 reset;
   logic [4:0]           cfg_shift;
   logic                 cfg_relu;
   logic [INW-1:0]       IN_AXIS_TDATA;
   logic                 IN_AXIS_TVALID;
   logic                 IN_AXIS_TREADY;
   logic [PACK*OUTW-1:0] OUT_AXIS_TDATA;
   logic [PACK-1:0]      OUT_AXIS_TKEEP;
   logic                 OUT_AXIS_TLAST;
   logic                 OUT_AXIS_TVALID;
   logic                 OUT_AXIS_TREADY;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   word_t exp_q[$];
   word_t obs_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    m_pos       = 0;
   int    m_lanes[$];
   int    m_shift     = 0;
   bit    m_relu      = 0;
   bit    rand_ready  = 0;

   out_requant_pack #(
      .INW     (INW),
      .OUTW    (OUTW),
      .PACK    (PACK),
      .NUM_OUT (NUM_OUT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cfg_shift       (cfg_shift),
      .cfg_relu        (cfg_relu),
      .IN_AXIS_TDATA   (IN_AXIS_TDATA),
      .IN_AXIS_TVALID  (IN_AXIS_TVALID),
      .IN_AXIS_TREADY  (IN_AXIS_TREADY),
      .OUT_AXIS_TDATA  (OUT_AXIS_TDATA),
      .OUT_AXIS_TKEEP  (OUT_AXIS_TKEEP),
      .OUT_AXIS_TLAST  (OUT_AXIS_TLAST),
      .OUT_AXIS_TVALID (OUT_AXIS_TVALID),
      .OUT_AXIS_TREADY (OUT_AXIS_TREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change only 1ns after a rising edge, so a handshake seen at the
   // falling edge is the one that completes on the next rising edge.
   always @(negedge clk) begin
      word_t w;
      if (!reset && OUT_AXIS_TVALID && OUT_AXIS_TREADY) begin
         w.data = OUT_AXIS_TDATA;
         w.keep = OUT_AXIS_TKEEP;
         w.last = OUT_AXIS_TLAST;
         obs_q.push_back(w);
         $display("out word data=%08h keep=%h last=%0b", w.data, w.keep, w.last);
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 OUT_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      end
   end

   // Requantization from first principles: floor division by 2^s, then clamp.
   function automatic int ref_requant(input logic [23:0] d, input int s, input bit relu);
      longint v;
      longint p;
      longint q;
      v = longint'($signed(d));
      p = longint'(1) << s;
      if (relu && v < 0) v = 0;
      if (v >= 0) q = v / p;
      else        q = -((-v + p - 1) / p);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return int'(q);
   endfunction

   function automatic logic [23:0] rnd_val();
      logic [23:0] r;
      case ($urandom_range(0, 3))
         0:       r = 24'($signed($urandom_range(0, 600)) - 300);
         1:       r = 24'($urandom_range(0, 65535)) - 24'd32768;
         2:       r = 24'($urandom);
         default: r = $urandom_range(0, 1) ? 24'h7FFFFF : 24'h800000;
      endcase
      return r;
   endfunction

   task automatic model_accept(input logic [23:0] d);
      word_t w;
      if (m_pos == 0) begin
         m_shift = int'(cfg_shift);
         m_relu  = cfg_relu;
      end
      m_lanes.push_back(ref_requant(d, m_shift, m_relu));
      m_pos++;
      if (m_lanes.size() == PACK || m_pos == NUM_OUT) begin
         w.data = '0;
         for (int i = 0; i < m_lanes.size(); i++) begin
            w.data[8*i +: 8] = 8'(m_lanes[i]);
         end
         w.keep = 4'((1 << m_lanes.size()) - 1);
         w.last = (m_pos == NUM_OUT);
         exp_q.push_back(w);
         m_lanes.delete();
         if (m_pos == NUM_OUT) m_pos = 0;
      end
   endtask

   // Present one result and wait (bounded) for it to be accepted.
   task automatic send(input logic [23:0] d, output int waits);
      bit ok;
      ok             = 0;
      waits          = 0;
      IN_AXIS_TDATA  = d;
      IN_AXIS_TVALID = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (IN_AXIS_TREADY) begin
            ok = 1;
            break;
         end
         waits++;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: IN_AXIS_TREADY got 0 for 200 cycles, expected 1");
      end else begin
         model_accept(d);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      IN_AXIS_TVALID = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      IN_AXIS_TVALID  = 1'b0;
      OUT_AXIS_TREADY = 1'b1;
      reset           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      m_pos = 0;
      m_lanes.delete();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      IN_AXIS_TVALID = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (IN_AXIS_TREADY !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %0b expected 0", IN_AXIS_TREADY);
      end
      vectors++;
      if ({OUT_AXIS_TVALID, OUT_AXIS_TLAST, OUT_AXIS_TKEEP, OUT_AXIS_TDATA} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%0b last=%0b keep=%h data=%h expected all 0",
                  OUT_AXIS_TVALID, OUT_AXIS_TLAST, OUT_AXIS_TKEEP, OUT_AXIS_TDATA);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (IN_AXIS_TREADY !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_in_ready: got %0b expected 1", IN_AXIS_TREADY);
      end
      vectors++;
      if (OUT_AXIS_TVALID !== 1'b0 || OUT_AXIS_TKEEP !== 4'h0) begin
         miscompares++;
         $display("FAIL idle_outputs: got valid=%0b keep=%h expected valid=0 keep=0",
                  OUT_AXIS_TVALID, OUT_AXIS_TKEEP);
      end
      $display("test_reset done");
   endtask

   task automatic test_shift();
      int w;
      reset_dut();
      cfg_shift = 5'd4;
      cfg_relu  = 1'b0;
      send(24'h000100, w);
      send(24'hFFFF00, w);
      send(24'h7FFFFF, w);
      send(24'h000000, w);
      IN_AXIS_TVALID = 1'b0;
      @(negedge clk);
      vectors++;
      if (OUT_AXIS_TVALID !== 1'b1) begin
         miscompares++;
         $display("FAIL shift_latency: TVALID got %0b expected 1 one cycle after completion", OUT_AXIS_TVALID);
      end
      vectors++;
      if ({OUT_AXIS_TDATA, OUT_AXIS_TKEEP, OUT_AXIS_TLAST} !== {32'h007FF010, 4'hF, 1'b0}) begin
         miscompares++;
         $display("FAIL shift_word: got data=%h keep=%h last=%0b expected data=007ff010 keep=f last=0",
                  OUT_AXIS_TDATA, OUT_AXIS_TKEEP, OUT_AXIS_TLAST);
      end
      idle(4);
      $display("test_shift done");
   endtask

   task automatic test_relu();
      int w;
      reset_dut();
      cfg_shift = 5'd0;
      cfg_relu  = 1'b1;
      send(-24'sd5, w);
      send(24'sd3, w);
      send(24'sd200, w);
      send(-24'sd1, w);
      idle(4);
      vectors++;
      if (obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL relu_count: got %0d words expected 1", obs_q.size());
      end else if (obs_q[0].data !== 32'h007F0300) begin
         miscompares++;
         $display("FAIL relu_word: got %h expected 007f0300", obs_q[0].data);
      end
      $display("test_relu done");
   endtask

   task automatic test_frame();
      int w;
      reset_dut();
      cfg_shift = 5'($urandom_range(0, 12));
      cfg_relu  = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_OUT; i++) begin
         send(rnd_val(), w);
         // Mid-frame config changes must have no effect on this frame.
         cfg_shift = 5'($urandom_range(0, 12));
         cfg_relu  = 1'($urandom_range(0, 1));
      end
      idle(4);
      vectors++;
      if (obs_q.size() != 2) begin
         miscompares++;
         $display("FAIL frame_count: got %0d words expected 2", obs_q.size());
      end else begin
         vectors++;
         if (obs_q[0].keep !== 4'hF || obs_q[0].last !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_word1: got keep=%h last=%0b expected keep=f last=0", obs_q[0].keep, obs_q[0].last);
         end
         vectors++;
         if (obs_q[1].keep !== 4'h3 || obs_q[1].last !== 1'b1 || obs_q[1].data[31:16] !== 16'h0) begin
            miscompares++;
            $display("FAIL frame_word2: got keep=%h last=%0b upper=%h expected keep=3 last=1 upper=0000",
                     obs_q[1].keep, obs_q[1].last, obs_q[1].data[31:16]);
         end
      end
      // A new frame starts with fresh live config.
      for (int i = 0; i < PACK; i++) begin
         send(rnd_val(), w);
         cfg_shift = 5'($urandom_range(0, 12));
         cfg_relu  = 1'($urandom_range(0, 1));
      end
      idle(4);
      vectors++;
      if (obs_q.size() != 3) begin
         miscompares++;
         $display("FAIL frame_next_count: got %0d words expected 3", obs_q.size());
      end else if (obs_q[2].keep !== 4'hF || obs_q[2].last !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_next_word: got keep=%h last=%0b expected keep=f last=0", obs_q[2].keep, obs_q[2].last);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL frame_model[%0d]: got %h/%h/%0b expected %h/%h/%0b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
      $display("test_frame done");
   endtask

   task automatic test_back_pressure();
      int w;
      logic [36:0] held;
      reset_dut();
      cfg_shift = 5'($urandom_range(0, 10));
      cfg_relu  = 1'b0;
      OUT_AXIS_TREADY = 1'b0;
      for (int i = 0; i < PACK; i++) send(rnd_val(), w);
      IN_AXIS_TDATA  = rnd_val();
      IN_AXIS_TVALID = 1'b1;
      @(negedge clk);
      held = {OUT_AXIS_TDATA, OUT_AXIS_TKEEP, OUT_AXIS_TLAST};
      vectors++;
      if (exp_q.size() != 1 || held !== {exp_q[0].data, exp_q[0].keep, exp_q[0].last}) begin
         miscompares++;
         $display("FAIL bp_word: got %h expected first model word", held);
      end
      for (int c = 0; c < 10; c++) begin
         vectors++;
         if (IN_AXIS_TREADY !== 1'b0 || OUT_AXIS_TVALID !== 1'b1 ||
             {OUT_AXIS_TDATA, OUT_AXIS_TKEEP, OUT_AXIS_TLAST} !== held) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got in_ready=%0b valid=%0b word=%h expected 0/1/%h", c,
                     IN_AXIS_TREADY, OUT_AXIS_TVALID, {OUT_AXIS_TDATA, OUT_AXIS_TKEEP, OUT_AXIS_TLAST}, held);
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      OUT_AXIS_TREADY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send((i == 0) ? IN_AXIS_TDATA : rnd_val(), w);
         vectors++;
         if (w != 0) begin
            miscompares++;
            $display("FAIL bp_stream[%0d]: waited %0d cycles expected 0", i, w);
         end
      end
      idle(4);
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL bp_count: got %0d words expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL bp_model[%0d]: got %h/%h/%0b expected %h/%h/%0b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
      $display("test_back_pressure done");
   endtask

   task automatic test_random();
      int w;
      reset_dut();
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         cfg_shift = 5'($urandom_range(0, 23));
         cfg_relu  = 1'($urandom_range(0, 1));
         send(rnd_val(), w);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      OUT_AXIS_TREADY = 1'b1;
      idle(4);
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL rand_count: got %0d words expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rand_model[%0d]: got %h/%h/%0b expected %h/%h/%0b", i,
                     obs_q[i].data, obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
         end
      end
      $display("test_random done");
   endtask

   task automatic test_reset_partial();
      int w;
      reset_dut();
      cfg_shift = 5'd2;
      cfg_relu  = 1'b0;
      send(24'h000400, w);
      send(24'h000800, w);
      reset_dut();
      cfg_shift = 5'($urandom_range(0, 8));
      for (int i = 0; i < PACK; i++) send(rnd_val(), w);
      idle(4);
      vectors++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         miscompares++;
         $display("FAIL partial_count: got %0d words expected 1", obs_q.size());
      end else if (obs_q[0] !== exp_q[0]) begin
         miscompares++;
         $display("FAIL partial_word: got %h/%h/%0b expected %h/%h/%0b",
                  obs_q[0].data, obs_q[0].keep, obs_q[0].last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
      end
      $display("test_reset_partial done");
   endtask

   initial begin
      reset           = 1'b1;
      cfg_shift       = '0;
      cfg_relu        = 1'b0;
      IN_AXIS_TDATA   = '0;
      IN_AXIS_TVALID  = 1'b0;
      OUT_AXIS_TREADY = 1'b1;
      test_reset();
      test_shift();
      test_relu();
      test_frame();
      test_back_pressure();
      test_random();
      test_reset_partial();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
